// File: rtl/apu_wave_seq.sv
`default_nettype none
// ============================================================================
// Module   : apu_wave_seq
// Brief    : Timer-driven triangle/pulse step sequencer with length counter
//            and linear volume, producing a registered PCM sample.
// Revision : 1.0  initial release
// ============================================================================
module apu_wave_seq #(
  parameter int TIMER_W = 11,
  parameter int OUT_W   = 16,
  parameter int LEN_W   = 8
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               tick_en,
  input  logic               half_tick,
  input  logic               period_wr,
  input  logic [TIMER_W-1:0] period,
  input  logic               mode,
  input  logic [1:0]         duty,
  input  logic [3:0]         volume,
  input  logic               enable,
  input  logic               len_load,
  input  logic [LEN_W-1:0]   len_val,
  input  logic               halt,
  output logic [OUT_W-1:0]   sample,
  output logic               active,
  output logic               step
);

  localparam logic [7:0]         C_DUTY0       = 8'b0000_0010;
  localparam logic [7:0]         C_DUTY1       = 8'b0000_0110;
  localparam logic [7:0]         C_DUTY2       = 8'b0001_1110;
  localparam logic [7:0]         C_DUTY3       = 8'b1111_1001;
  localparam logic [TIMER_W-1:0] C_MUTE_PERIOD = TIMER_W'(8);
  localparam logic [TIMER_W-1:0] C_TIMER_ONE   = TIMER_W'(1);
  localparam logic [LEN_W-1:0]   C_LEN_ONE     = LEN_W'(1);

  logic [TIMER_W-1:0] period_q, period_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [4:0]         seq_q, seq_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               mode_q, mode_d;
  logic [OUT_W-1:0]   sample_q, sample_d;
  logic               step_q, step_d;

  logic       step_evt;
  logic       mode_chg;
  logic       len_nz;
  logic       advance;
  logic [7:0] duty_pat;
  logic [3:0] tri_level;
  logic [3:0] pulse_level;
  logic [3:0] level;
  logic [7:0] prod;

  assign len_nz   = (len_q != '0);
  assign step_evt = tick_en && (timer_q == '0);
  assign mode_chg = (mode != mode_q);
  // Triangle stalls while the length counter is empty; pulse keeps running.
  assign advance  = step_evt && !mode_chg && (mode_q || len_nz);

  // Waveform level from the current sequencer position.
  always_comb begin
    duty_pat = C_DUTY0;
    case (duty)
      2'd0:    duty_pat = C_DUTY0;
      2'd1:    duty_pat = C_DUTY1;
      2'd2:    duty_pat = C_DUTY2;
      default: duty_pat = C_DUTY3;
    endcase
    // seq<16 counts down as ~seq[3:0], seq>=16 counts up as seq[3:0].
    tri_level   = seq_q[4] ? seq_q[3:0] : ~seq_q[3:0];
    pulse_level = duty_pat[seq_q[2:0]] ? 4'hF : 4'h0;
    if (!len_nz || (period_q < C_MUTE_PERIOD)) begin
      pulse_level = 4'h0;
    end
    level = mode_q ? pulse_level : tri_level;
    prod  = {4'b0000, level} * {4'b0000, volume};
  end

  always_comb begin
    period_d = period_wr ? period : period_q;

    timer_d = timer_q;
    if (tick_en) begin
      timer_d = (timer_q == '0) ? period_q : (timer_q - C_TIMER_ONE);
    end

    mode_d = mode;
    seq_d  = seq_q;
    if (mode_chg) begin
      seq_d = 5'd0;
    end else if (advance) begin
      seq_d = mode_q ? {2'b00, seq_q[2:0] + 3'd1} : (seq_q + 5'd1);
    end
    step_d = advance;

    len_d = len_q;
    if (!enable) begin
      len_d = '0;
    end else if (len_load) begin
      len_d = len_val;
    end else if (half_tick && !halt && len_nz) begin
      len_d = len_q - C_LEN_ONE;
    end

    // 8-bit product sits below two bits of headroom.
    sample_d              = '0;
    sample_d[OUT_W-3 -: 8] = prod;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      period_q <= '0;
      timer_q  <= '0;
      seq_q    <= 5'd0;
      len_q    <= '0;
      mode_q   <= 1'b0;
      sample_q <= '0;
      step_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      timer_q  <= timer_d;
      seq_q    <= seq_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      sample_q <= sample_d;
      step_q   <= step_d;
    end
  end

  assign sample = sample_q;
  assign step   = step_q;
  assign active = len_nz;

endmodule
`default_nettype wire

// File: tb/tb_apu_wave_seq.sv
`default_nettype none
// Testbench for apu_wave_seq: directed stimulus with a step-driven sample scoreboard.
module tb_apu_wave_seq;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        tick_en, half_tick, period_wr, mode, enable, len_load, halt;
  logic [10:0] period;
  logic [1:0]  duty;
  logic [3:0]  volume;
  logic [7:0]  len_val;
  logic [15:0] sample;
  logic        active, step;

  apu_wave_seq #(.TIMER_W(11), .OUT_W(16), .LEN_W(8)) dut (
    .clk(clk), .rst_l(rst_l), .tick_en(tick_en), .half_tick(half_tick),
    .period_wr(period_wr), .period(period), .mode(mode), .duty(duty),
    .volume(volume), .enable(enable), .len_load(len_load), .len_val(len_val),
    .halt(halt), .sample(sample), .active(active), .step(step)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic        pend   = 1'b0;

  // Hand-written triangle levels for seq_i = 0..31.
  int tri_lv [32] = '{15,14,13,12,11,10,9,8,7,6,5,4,3,2,1,0,
                      0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_steps(input int n);
    int cnt = 0;
    int c   = 0;
    while (cnt < n && c < n * 20 + 40) begin
      @(posedge clk);
      #1;
      c++;
      if (step) cnt++;
    end
    n_vec++;
    if (cnt != n) begin
      n_err++;
      $display("FAIL step_timeout: got %0d steps, expected %0d", cnt, n);
    end
  endtask

  task automatic push_tri(input int first, input int count, input int vol);
    for (int i = 0; i < count; i++) begin
      exp_q.push_back(16'(tri_lv[(first + i) % 32] * vol * 64));
    end
  endtask

  // Monitor: one cycle after each step pulse the new level reaches sample.
  always begin
    @(posedge clk);
    #2;
    if (pend) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: unexpected step, sample %h, expected no step", sample);
      end else begin
        check("sb_sample", sample, exp_q.pop_front());
      end
    end
    pend = mon_en && step;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pul [10];
    pul = '{16'h03C0, 16'h03C0, 16'h03C0, 16'h03C0, 16'h0000,
            16'h0000, 16'h0000, 16'h0000, 16'h03C0, 16'h03C0};

    rst_l = 1'b0; tick_en = 0; half_tick = 0; period_wr = 0; period = '0;
    mode = 0; duty = 2'd0; volume = 4'd0; enable = 0; len_load = 0;
    len_val = '0; halt = 0;
    #12;
    check("rst_sample", sample, 16'h0000);
    check("rst_active", 16'(active), 16'd0);
    check("rst_step",   16'(step),   16'd0);

    // Triangle, period 3, full volume, full 32-step cycle.
    @(negedge clk);
    rst_l = 1'b1;
    enable = 1; len_load = 1; len_val = 8'd10; period_wr = 1; period = 11'd3;
    volume = 4'd15; mode = 0;
    cyc(1);
    len_load = 0; period_wr = 0;
    check("len_loaded", 16'(active), 16'd1);
    cyc(1);
    check("tri_seq0", sample, 16'h3840);
    push_tri(1, 32, 15);
    mon_en = 1; tick_en = 1;
    wait_steps(32);
    tick_en = 0;
    cyc(2);

    // Pulse duty2, period 8, volume 1; then period 7 mutes.
    mode = 1; duty = 2'd2; volume = 4'd1; period_wr = 1; period = 11'd8;
    cyc(1);
    period_wr = 0;
    cyc(1);
    check("pulse_seq0", sample, 16'h0000);
    for (int i = 0; i < 10; i++) exp_q.push_back(pul[i]);
    tick_en = 1;
    wait_steps(10);
    tick_en = 0;
    cyc(2);
    period_wr = 1; period = 11'd7;
    cyc(1);
    period_wr = 0;
    cyc(1);
    check("pulse_mute_p7", sample, 16'h0000);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h0000);
    tick_en = 1;
    wait_steps(4);
    tick_en = 0;
    cyc(2);

    // Length expiry freezes the triangle; halt holds the counter.
    mode = 0; period_wr = 1; period = 11'd3; volume = 4'd15;
    len_load = 1; len_val = 8'd2;
    cyc(1);
    period_wr = 0; len_load = 0;
    push_tri(1, 5, 15);
    tick_en = 1;
    wait_steps(5);
    tick_en = 0;
    cyc(2);
    half_tick = 1; cyc(1); half_tick = 0;
    check("len_dec1", 16'(active), 16'd1);
    half_tick = 1; cyc(1); half_tick = 0;
    check("len_dec2", 16'(active), 16'd0);
    tick_en = 1;
    cyc(20);
    tick_en = 0;
    check("tri_hold", sample, 16'h2580);
    halt = 1; len_load = 1; len_val = 8'd2;
    cyc(1);
    len_load = 0;
    repeat (2) begin half_tick = 1; cyc(1); half_tick = 0; end
    check("len_halt", 16'(active), 16'd1);
    halt = 0;

    // Load beats half_tick; enable=0 beats load; zero saturates.
    len_load = 1; len_val = 8'd3; cyc(1);
    len_val = 8'd5; half_tick = 1; cyc(1);
    len_load = 0; half_tick = 0;
    repeat (4) begin half_tick = 1; cyc(1); half_tick = 0; end
    check("load_wins_a", 16'(active), 16'd1);
    half_tick = 1; cyc(1); half_tick = 0;
    check("load_wins_b", 16'(active), 16'd0);
    half_tick = 1; cyc(1); half_tick = 0;
    check("len_sat", 16'(active), 16'd0);
    len_load = 1; len_val = 8'd5; cyc(1); len_load = 0;
    check("len_reload", 16'(active), 16'd1);
    enable = 0; len_load = 1; cyc(1);
    check("en_off_load", 16'(active), 16'd0);
    enable = 1; len_load = 0; cyc(1);
    check("en_off_stays", 16'(active), 16'd0);

    // Mode toggle coincident with the step that would reach seq 14.
    mode = 1; len_load = 1; len_val = 8'd20; period_wr = 1; period = 11'd8;
    cyc(1);
    mode = 0; len_load = 0; period_wr = 0;
    cyc(1);
    push_tri(1, 13, 15);
    tick_en = 1;
    wait_steps(13);
    cyc(8);
    mode = 1; duty = 2'd1;
    cyc(1);
    check("mode_sw_nostep", 16'(step), 16'd0);
    exp_q.push_back(16'h3840);
    exp_q.push_back(16'h3840);
    exp_q.push_back(16'h0000);
    wait_steps(3);
    tick_en = 0;
    cyc(2);

    // Asynchronous reset mid-sequence.
    mon_en = 0;
    tick_en = 1;
    wait_steps(1);
    #2;
    rst_l = 1'b0;
    #1;
    check("arst_sample", sample, 16'h0000);
    check("arst_active", 16'(active), 16'd0);
    check("arst_step",   16'(step),   16'd0);
    tick_en = 0; mode = 0; enable = 1; len_load = 1; len_val = 8'd10;
    cyc(1);
    @(negedge clk);
    rst_l = 1'b1;
    cyc(1);
    check("rst_reload", 16'(active), 16'd1);
    len_load = 0; tick_en = 1; mon_en = 1;
    exp_q.push_back(16'h3480);
    exp_q.push_back(16'h30C0);
    cyc(1);
    check("rst_first_step", 16'(step), 16'd1);
    cyc(1);
    check("p0_every_tick", 16'(step), 16'd1);
    tick_en = 0;
    cyc(3);
    check("sb_drain", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apu_wave_seq.md
Name: apu_wave_seq

Overview:
- Parametrised step-sequencer tone channel for the APU synth path.
- Generalises the fixed 32-step triangle test tone into a timer-driven generator with two modes:
  - triangle: 32-step F..0,0..F ramp
  - pulse: 8-step, 4 selectable duties
- Adds a programmable period register, a length counter with halt, and volume scaling.
- Output is a registered PCM sample feeding audio_dac or the APU mixer.

Parameters:
- TIMER_W, 11, width of period register and step timer.
- OUT_W, 16, width of PCM sample; must be >= 10.
- LEN_W, 8, width of length counter.

Ports:
- clk  input  1  system clock.
- rst_l  input  1  asynchronous active-low reset.
- tick_en  input  1  timer clock enable (one APU cycle).
- half_tick  input  1  frame-sequencer half-frame pulse; decrements length counter.
- period_wr  input  1  latch period into period_q.
- period  input  TIMER_W  new period value.
- mode  input  1  0 = triangle, 1 = pulse.
- duty  input  2  pulse duty select.
- volume  input  4  linear output gain, 0..15.
- enable  input  1  channel enable.
- len_load  input  1  load length counter.
- len_val  input  LEN_W  length load value.
- halt  input  1  freeze length counter.
- sample  output  OUT_W  PCM sample.
- active  output  1  length counter nonzero.
- step  output  1  one-cycle pulse on each sequencer advance.

Behaviour:
- Reset (async, rst_l low): period_q=0, timer=0, seq_i=0, len_cnt=0, mode_q=0, sample=0, active=0, step=0.
- period_wr: period_q <= period next edge. Timer is not reloaded; the new period takes effect at the next underflow.

Timer:
- Only when tick_en=1.
- If timer==0: timer<=period_q and a step event occurs. Else timer<=timer-1.
- Period P therefore gives one step every P+1 enabled ticks. P=0 steps on every tick.

Sequencer (5-bit seq_i):
- Advances on a step event:
  - triangle: requires len_cnt!=0; wraps 31->0.
  - pulse: advances unconditionally; uses seq_i[2:0] and wraps 7->0 (seq_i[4:3] forced 0).
- step output = registered step event that actually advanced seq_i.
- Mode change (mode != mode_q): seq_i<=0 the same edge, mode_q<=mode, and any step event that cycle is discarded.

Level (4-bit):
- triangle: seq_i<16 ? 15-seq_i : seq_i-16.
- pulse: bit seq_i[2:0] (bit 0 first) of the duty pattern, times 15:
  - duty0 = 8'b00000010
  - duty1 = 8'b00000110
  - duty2 = 8'b00011110
  - duty3 = 8'b11111001
- pulse mute: level forced to 0 if len_cnt==0 or period_q<8.
- triangle at len_cnt==0 holds its current level (no click).

Length counter:
- enable=0 forces len_cnt<=0 every cycle; this overrides len_load.
- Else len_load => len_cnt<=len_val.
- Else half_tick && !halt && len_cnt!=0 => len_cnt-1.
- Load wins over a simultaneous half_tick. Saturates at 0 (no wrap).
- active = (len_cnt!=0), combinational from the register.

Sample:
- prod = level*volume (8-bit unsigned, max 225).
- sample registered: sample[OUT_W-3 -: 8]=prod, all other bits 0 (2 bits headroom).
- Latency: 1 clk from a level/volume change to sample.
- Reset mid-operation returns all state to reset values immediately; no partial step completes.

Test Plan:
1. Reset, enable=1, len_load len_val=10, mode=0, period=3, tick_en=1 constant -> step every 4 clks; seq_i 0..31 wraps to 0. For OUT_W=16, volume=15: sample at seq_i=0 = 225<<6 = 0x3840; at seq_i=15 and 16 = 0.
2. Pulse duty2, period=8, volume=1 -> sample pattern over 8 steps = 0,15,15,15,15,0,0,0 (in units of 1<<6). Then period_wr period=7 -> sample stuck at 0 after the write, while step pulses continue.
3. len_val=2, halt=0, two half_tick pulses -> active falls after the 2nd. Triangle seq_i frozen at its value and sample held. Repeat with halt=1 -> active stays 1.
4. Simultaneous len_load (len_val=5) and half_tick with len_cnt=3 -> len_cnt=5. With enable=0 plus len_load -> len_cnt=0.
5. Toggle mode at seq_i=13 on the same cycle as a step event -> seq_i=0, no step pulse that cycle.
6. Assert rst_l low mid-sequence (asynchronous, between edges) -> sample=0, active=0, step=0 immediately. After release, the first step occurs on the first tick_en, since timer=0.
